// File: rtl/neuron_step_ctrl.sv
// Time-step sequencer: walks every neuron through BRAM fetch, current load and
// one updater run, collecting spikes. Define SPIKE_COUNT_EN to add spike_cnt.
module neuron_step_ctrl #(
  parameter int N_NEURON = 18,
  parameter int TIMEOUT  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               init_req,
  output logic               busy,
  output logic [4:0]         addr_i,
  output logic               ce_i,
  input  logic [49:0]        q_i,
  output logic               i_run,
  output logic               i_init,
  output logic signed [24:0] exc_current,
  output logic signed [24:0] inh_current,
  input  logic               o_s_init,
  input  logic               o_spike,
  input  logic               o_valid,
  input  logic [4:0]         o_neuron_idx,
  output logic [31:0]        spike_vec,
  output logic               step_done,
`ifdef SPIKE_COUNT_EN
  output logic [5:0]         spike_cnt,
`endif
  output logic               err
);

  localparam int          WD_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]  LAST_IDX   = 5'(N_NEURON - 1);
  localparam logic [1:0]  INIT_LIMIT = 2'd3;
  localparam logic [31:0] VALID_MASK = 32'((64'd1 << N_NEURON) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_FETCH, S_LOAD, S_RUN, S_WAIT, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [4:0]        idx;
  logic [31:0]       work_vec;
  logic [WD_W-1:0]   wdog;
  logic [1:0]        init_cnt;
  logic              seen_high;
  logic              publish;

  logic init_fall, init_timeout, neuron_done, wd_expire, last;

  assign last         = (idx == LAST_IDX);
  assign init_fall    = (state == S_INIT_WAIT) && seen_high && !o_s_init;
  assign init_timeout = (state == S_INIT_WAIT) && !seen_high && !o_s_init &&
                        (init_cnt == INIT_LIMIT);
  assign neuron_done  = (state == S_WAIT) && o_valid;
  // A late o_valid on the expiry cycle still counts as a normal completion.
  assign wd_expire    = (state == S_WAIT) && !o_valid && (wdog == WD_W'(TIMEOUT - 1));

`ifdef SPIKE_COUNT_EN
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int k = 0; k < 32; k++) popcount += 6'(v[k]);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    // NOTE: defaulting first means every path assigns state_d, so no latch is inferred.
    state_d = state;
    case (state)
      S_IDLE: begin
        if (init_req)   state_d = S_INIT;
        else if (start) state_d = S_FETCH;
      end
      S_INIT:      state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (init_fall || init_timeout) state_d = S_DONE;
      S_FETCH:     state_d = S_LOAD;
      S_LOAD:      state_d = S_RUN;
      S_RUN:       state_d = S_WAIT;
      S_WAIT: begin
        if (neuron_done)    state_d = last ? S_DONE : S_FETCH;
        else if (wd_expire) state_d = S_DONE;
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    i_init    = (state == S_INIT);
    ce_i      = (state == S_FETCH);
    addr_i    = (state == S_FETCH) ? idx : 5'd0;
    i_run     = (state == S_RUN);
    step_done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
    if (!reset_n) begin
      idx         <= '0;
      work_vec    <= '0;
      spike_vec   <= '0;
      exc_current <= '0;
      inh_current <= '0;
      err         <= 1'b0;
      wdog        <= '0;
      init_cnt    <= '0;
      seen_high   <= 1'b0;
      publish     <= 1'b0;
`ifdef SPIKE_COUNT_EN
      spike_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (init_req || start) begin
            err     <= 1'b0;
            idx     <= '0;
            publish <= 1'b0;
          end
        end
        S_INIT: begin
          init_cnt  <= '0;
          seen_high <= 1'b0;
        end
        S_INIT_WAIT: begin
          init_cnt <= init_cnt + 2'd1;
          if (o_s_init)     seen_high <= 1'b1;
          if (init_timeout) err       <= 1'b1;
        end
        S_LOAD: begin
          exc_current <= q_i[49:25];
          inh_current <= q_i[24:0];
        end
        S_RUN: wdog <= WD_W'(1);
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          if (o_valid) begin
            work_vec[idx] <= work_vec[idx] | o_spike;
            if (o_neuron_idx != idx) err <= 1'b1;
            if (last) publish <= 1'b1;
            else      idx     <= idx + 5'd1;
          end else if (wd_expire) begin
            // An abandoned step publishes nothing; its partial bitmap is dropped.
            err      <= 1'b1;
            work_vec <= '0;
          end
        end
        S_DONE: begin
          work_vec <= '0;
          if (publish) begin
            spike_vec <= work_vec & VALID_MASK;
`ifdef SPIKE_COUNT_EN
            spike_cnt <= popcount(work_vec & VALID_MASK);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_step_ctrl.sv
// Self-checking bench for neuron_step_ctrl: BRAM + updater behavioural model,
// vector table, directed corner sequences and randomized steps.
module tb_neuron_step_ctrl;

  localparam int N_NEURON = 18;
  localparam int TIMEOUT  = 32;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               init_req = 1'b0;
  logic               busy, ce_i, i_run, i_init, step_done, err;
  logic [4:0]         addr_i;
  logic [49:0]        q_i = '0;
  logic signed [24:0] exc_current, inh_current;
  logic               o_s_init = 1'b0;
  logic               o_spike = 1'b0;
  logic               o_valid = 1'b0;
  logic [4:0]         o_neuron_idx = '0;
  logic [31:0]        spike_vec;
`ifdef SPIKE_COUNT_EN
  logic [5:0]         spike_cnt;
`endif

  neuron_step_ctrl #(.N_NEURON(N_NEURON), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .init_req(init_req),
    .busy(busy), .addr_i(addr_i), .ce_i(ce_i), .q_i(q_i),
    .i_run(i_run), .i_init(i_init),
    .exc_current(exc_current), .inh_current(inh_current),
    .o_s_init(o_s_init), .o_spike(o_spike), .o_valid(o_valid),
    .o_neuron_idx(o_neuron_idx), .spike_vec(spike_vec), .step_done(step_done),
`ifdef SPIKE_COUNT_EN
    .spike_cnt(spike_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Model configuration, owned by the stimulus process.
  logic [49:0] mem [32];
  logic [31:0] m_mask = '0;
  int          m_lat = 1, m_bad = -1, m_drop = -1, m_ihold = 18, clr_seq = 0;

  // Model observations, owned by the model process.
  int          cyc = 0, clr_seen = 0, run_count = 0, valid_cnt = 0, fetch_count = 0;
  int          first_fetch_addr = -1, init_pulses = 0, init_cyc = 0, done_count = 0;
  int          done_cyc = 0, last_sinit_cyc = 0, err_rise_cyc = -1;
  int          run_cyc [32];
  logic [24:0] run_exc [32], run_inh [32], valid_exc [32];
  int          valid_cd = -1, sinit_rem = 0, cur_n = 0;
  bit          rd_pend = 1'b0, err_q = 1'b0;
  logic [4:0]  rd_addr = '0;

  // BRAM with one-cycle read latency plus an updater that answers each i_run
  // after m_lat cycles, reporting neuron number = order of i_run in the step.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq; run_count = 0; valid_cnt = 0; fetch_count = 0;
      first_fetch_addr = -1; init_pulses = 0; err_rise_cyc = -1;
    end
    if (!reset_n) begin
      o_valid = 1'b0; o_spike = 1'b0; o_neuron_idx = '0; o_s_init = 1'b0;
      q_i = '0; valid_cd = -1; sinit_rem = 0; rd_pend = 1'b0; err_q = 1'b0;
    end else begin
      q_i = rd_pend ? mem[rd_addr] : 50'({$urandom(), $urandom()});
      rd_pend = ce_i;
      rd_addr = addr_i;
      if (ce_i) begin
        if (fetch_count == 0) first_fetch_addr = int'(addr_i);
        fetch_count++;
      end
      o_s_init = (sinit_rem > 0);
      if (sinit_rem > 0) begin sinit_rem--; last_sinit_cyc = cyc; end
      if (i_init) begin init_pulses++; init_cyc = cyc; sinit_rem = m_ihold; end
      o_valid = 1'b0; o_spike = 1'b0; o_neuron_idx = '0;
      if (valid_cd > 0) begin
        valid_cd--;
        if (valid_cd == 0) begin
          o_valid      = 1'b1;
          o_spike      = m_mask[cur_n];
          o_neuron_idx = (cur_n == m_bad) ? 5'(cur_n + 1) : 5'(cur_n);
          if (valid_cnt < 32) valid_exc[valid_cnt] = exc_current;
          valid_cnt++;
          valid_cd = -1;
        end
      end
      if (i_run) begin
        cur_n = run_count;
        if (run_count < 32) begin
          run_cyc[run_count] = cyc;
          run_exc[run_count] = exc_current;
          run_inh[run_count] = inh_current;
        end
        run_count++;
        valid_cd = (cur_n == m_drop) ? -1 : m_lat;
      end
      if (step_done) begin done_count++; done_cyc = cyc; end
      if (err && !err_q) err_rise_cyc = cyc;
      err_q = err;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    clr_seq++;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_init();
    init_req = 1'b1; @(negedge clk); init_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base = done_count;
    bit got  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_count != base) begin got = 1'b1; break; end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctrl_outputs"}, {busy, i_run, i_init, ce_i, addr_i, step_done, err}, '0);
    check({tag, "_currents"}, {exc_current, inh_current}, '0);
    check({tag, "_spike_vec"}, spike_vec, '0);
`ifdef SPIKE_COUNT_EN
    check({tag, "_spike_cnt"}, spike_cnt, '0);
`endif
  endtask

  // Currents seen at each i_run and each o_valid must be the fetched word,
  // and consecutive runs must be exactly three cycles plus the updater latency apart.
  task automatic verify_runs(input string tag, input int exp_runs);
    logic [49:0] w;
    check({tag, "_runs"}, run_count, exp_runs);
    for (int n = 0; n < run_count && n < 32; n++) begin
      w = mem[n];
      check($sformatf("%s_exc%0d", tag, n), {39'b0, run_exc[n]}, {39'b0, w[49:25]});
      check($sformatf("%s_inh%0d", tag, n), {39'b0, run_inh[n]}, {39'b0, w[24:0]});
      if (n > 0) check($sformatf("%s_gap%0d", tag, n), run_cyc[n] - run_cyc[n-1], m_lat + 3);
    end
    for (int n = 0; n < valid_cnt && n < 32; n++) begin
      w = mem[n];
      check($sformatf("%s_hold%0d", tag, n), {39'b0, valid_exc[n]}, {39'b0, w[49:25]});
    end
  endtask

  typedef struct {
    logic [31:0] mask;
    int          lat;
    int          bad;
    logic [31:0] exp_vec;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] prev_vec, exp_vec;
  int          first_err, d;

  initial begin
    vecs[0] = '{32'hAAAA_AAAA, 1, -1, 32'h0002_AAAA, 1'b0, 9};
    vecs[1] = '{32'hFFFF_FFFF, 3, -1, 32'h0003_FFFF, 1'b0, 18};
    vecs[2] = '{32'h0000_0000, 1, -1, 32'h0000_0000, 1'b0, 0};
    vecs[3] = '{32'h5555_5555, 2,  3, 32'h0001_5555, 1'b1, 9};
    vecs[4] = '{32'h0002_0001, 5, -1, 32'h0002_0001, 1'b0, 2};
    for (int k = 0; k < 32; k++) mem[k] = {25'(k * 65536), 25'd0};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Initialisation handshake.
    clear_model(); m_ihold = 18;
    pulse_init();
    wait_done(200, "init");
    check("init_pulses", init_pulses, 1);
    check("init_done_delay", done_cyc - last_sinit_cyc, 2);
    check("init_err", err, 0);
    check("init_busy", busy, 0);
    check("init_runs", run_count, 0);

    for (int v = 0; v < 5; v++) begin
      clear_model();
      m_mask = vecs[v].mask; m_lat = vecs[v].lat; m_bad = vecs[v].bad; m_drop = -1;
      pulse_start();
      wait_done(1000, $sformatf("v%0d", v));
      verify_runs($sformatf("v%0d", v), N_NEURON);
      check($sformatf("v%0d_spike_vec", v), spike_vec, vecs[v].exp_vec);
      check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_busy", v), busy, 0);
`ifdef SPIKE_COUNT_EN
      check($sformatf("v%0d_spike_cnt", v), spike_cnt, vecs[v].exp_cnt);
`endif
    end

    // Updater never answers neuron 5: watchdog aborts, previous bitmap kept.
    clear_model(); m_mask = '1; m_lat = 2; m_bad = -1; m_drop = 5;
    prev_vec = spike_vec;
    pulse_start();
    wait_done(1000, "to");
    verify_runs("to", 6);
    check("to_err", err, 1);
    check("to_err_delay", err_rise_cyc - run_cyc[5], TIMEOUT);
    check("to_spike_vec", spike_vec, prev_vec);

    // Next accepted start clears err; the aborted partial bitmap must not leak.
    clear_model(); m_drop = -1; m_mask = 32'h0000_0100; m_lat = 1;
    pulse_start();
    check("err_clear_on_start", err, 0);
    wait_done(1000, "after_to");
    verify_runs("after_to", N_NEURON);
    check("after_to_spike_vec", spike_vec, 32'h0000_0100);

    // start and init_req together: init wins; later start while busy is dropped.
    clear_model(); m_ihold = 6;
    start = 1'b1; init_req = 1'b1;
    @(negedge clk);
    start = 1'b0; init_req = 1'b0;
    check("both_i_init", i_init, 1);
    check("both_no_fetch", ce_i, 0);
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done(200, "both");
    repeat (5) @(negedge clk);
    check("both_init_pulses", init_pulses, 1);
    check("both_fetches", fetch_count, 0);
    check("both_idle", busy, 0);
    check("both_err", err, 0);

    // Updater never raises o_s_init.
    clear_model(); m_ihold = 0;
    pulse_init();
    wait_done(50, "init_to");
    d = done_cyc - init_cyc;
    check("init_to_err", err, 1);
    check("init_to_delay_in_range", 64'(d >= 5 && d <= 6), 64'd1);
    m_ihold = 18;

    // Reset while waiting on neuron 7.
    clear_model(); m_mask = '1; m_lat = 10;
    pulse_start();
    first_err = 1;
    for (int i = 0; i < 1000; i++) begin
      if (run_count >= 8) begin first_err = 0; break; end
      @(negedge clk);
    end
    check("mid_reach_idx7", first_err, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_reset");
    reset_n = 1'b1;
    clear_model(); m_lat = 1; m_mask = 32'h0000_0F0F;
    pulse_start();
    wait_done(1000, "post_reset");
    check("post_reset_first_addr", first_fetch_addr, 0);
    verify_runs("post_reset", N_NEURON);
    check("post_reset_spike_vec", spike_vec, 32'h0000_0F0F);

    // Randomized steps against the reference: bitmap = mask restricted to real neurons.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 32; k++) mem[k] = 50'({$urandom(), $urandom()});
      clear_model();
      m_mask = $urandom();
      m_lat  = int'($urandom_range(1, 6));
      m_bad  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N_NEURON - 1)) : -1;
      exp_vec = '0;
      for (int k = 0; k < N_NEURON; k++) if (m_mask[k]) exp_vec |= (32'd1 << k);
      pulse_start();
      wait_done(2000, $sformatf("rnd%0d", r));
      verify_runs($sformatf("rnd%0d", r), N_NEURON);
      check($sformatf("rnd%0d_spike_vec", r), spike_vec, exp_vec);
      check($sformatf("rnd%0d_err", r), err, 64'(m_bad >= 0));
`ifdef SPIKE_COUNT_EN
      check($sformatf("rnd%0d_spike_cnt", r), spike_cnt, 64'($countones(exp_vec)));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
